// File: rtl/lockin_tracker.sv
// rtl/lockin_tracker.sv - edge-rate tracker with lock/unlock hysteresis and a moving drift average
// Optional macro LOCKIN_TRACKER_RATE_TRIM_EN folds the drift average back into the rate while locked.
module lockin_tracker #(
  parameter int RATE_WIDTH      = 16,
  parameter int LOCK_CNT_WIDTH  = 8,
  parameter int DRIFT_AVG_DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      sync_rst_n_i,
  input  logic                      clk_en_i,
  input  logic                      lockin_en_i,
  input  logic                      clear_state_i,
  input  logic                      event_i,
  input  logic [RATE_WIDTH-1:0]     rate_accumulator_i,
  input  logic [RATE_WIDTH-1:0]     drift_window_i,
  input  logic                      full_drift_direction_en_i,
  input  logic [LOCK_CNT_WIDTH-1:0] required_lockin_i,
  input  logic [LOCK_CNT_WIDTH-1:0] unlock_miss_limit_i,
  output logic [RATE_WIDTH-1:0]     active_rate_o,
  output logic                      active_rate_valid_o,
  output logic                      drift_valid_o,
  output logic                      drift_direction_o,
  output logic [RATE_WIDTH-1:0]     drift_amount_o,
  output logic [RATE_WIDTH:0]       avg_drift_o,
  output logic                      locked_in_o,
  output logic                      lock_lost_o,
  output logic [1:0]                state_o
);
  localparam int W  = RATE_WIDTH;
  localparam int CW = LOCK_CNT_WIDTH;
  localparam int AW = $clog2(DRIFT_AVG_DEPTH);
  localparam int SW = RATE_WIDTH + 1 + AW;
  localparam logic [W:0] ALL_ONES = {1'b0, {W{1'b1}}};

  typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, TRACK = 2'd2, LOCKED = 2'd3} state_t;
  typedef logic [DRIFT_AVG_DEPTH-1:0][W:0] hist_t;

  function automatic logic [W:0] hist_avg(input hist_t h);
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shifted;
    sum = '0;
    for (int i = 0; i < DRIFT_AVG_DEPTH; i++) sum = sum + SW'($signed(h[i]));
    shifted = sum >>> AW;
    return shifted[W:0];
  endfunction

  state_t          state_q, state_d;
  logic [W-1:0]    rate_q, rate_d, amount_q, amount_d;
  logic            rate_valid_q, rate_valid_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d, miss_cnt_q, miss_cnt_d;
  logic            dir_q, dir_d, dir_seen_q, dir_seen_d;
  logic            drift_pulse_q, drift_pulse_d, lost_q, lost_d, locked_q, locked_d;
  hist_t           hist_q, hist_d, hist_push;

  logic [W:0]      samp_x, rate_x, win_x, half_x, half_lo, half_hi, rate_lo, rate_hi;
  logic            is_late, is_early, late_ok, early_ok, half_hit, in_window;
  logic [W-1:0]    drift_amt;
  logic [W:0]      drift_val;
  logic [CW-1:0]   lock_inc, miss_inc, miss_limit;

  // All window bounds live one bit wider so the +win side cannot wrap.
  assign samp_x  = {1'b0, rate_accumulator_i};
  assign rate_x  = {1'b0, rate_q};
  assign win_x   = {1'b0, drift_window_i};
  assign half_x  = rate_x >> 1;
  assign half_hi = (half_x + win_x > ALL_ONES) ? ALL_ONES : half_x + win_x;
  assign half_lo = (half_x >= win_x) ? half_x - win_x : '0;
  assign rate_hi = (rate_x + win_x > ALL_ONES) ? ALL_ONES : rate_x + win_x;
  assign rate_lo = (rate_x >= win_x) ? rate_x - win_x : '0;

  assign is_late   = samp_x > rate_x;
  assign is_early  = samp_x < rate_x;
  assign late_ok   = full_drift_direction_en_i | ~dir_seen_q | dir_q;
  assign early_ok  = full_drift_direction_en_i | ~dir_seen_q | ~dir_q;
  assign half_hit  = (samp_x >= half_lo) && (samp_x <= half_hi);
  assign in_window = !half_hit && (is_late  ? (late_ok && samp_x <= rate_hi) :
                                   is_early ? (early_ok && samp_x >= rate_lo) : 1'b1);

  assign drift_amt = is_late ? rate_accumulator_i - rate_q : rate_q - rate_accumulator_i;
  assign drift_val = is_early ? -{1'b0, drift_amt} : {1'b0, drift_amt};
  assign hist_push = {hist_q[DRIFT_AVG_DEPTH-2:0], drift_val};

  assign lock_inc   = (lock_cnt_q == '1) ? lock_cnt_q : lock_cnt_q + CW'(1);
  assign miss_inc   = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + CW'(1);
  assign miss_limit = (unlock_miss_limit_i == '0) ? CW'(1) : unlock_miss_limit_i;

`ifdef LOCKIN_TRACKER_RATE_TRIM_EN
  localparam logic [AW:0]         TRIM_FULL  = (AW+1)'(DRIFT_AVG_DEPTH);
  localparam logic signed [W+1:0] RATE_ONE_S = (W+2)'(1);
  localparam logic signed [W+1:0] RATE_MAX_S = {2'b00, {W{1'b1}}};
  logic [AW:0]         trim_cnt_q, trim_cnt_d, trim_inc;
  logic [W:0]          trim_avg;
  logic signed [W+1:0] trim_sum;
  logic [W-1:0]        trim_rate;

  assign trim_inc  = (trim_cnt_q >= TRIM_FULL) ? TRIM_FULL : trim_cnt_q + (AW+1)'(1);
  assign trim_avg  = hist_avg(hist_push);
  assign trim_sum  = $signed({2'b00, rate_q}) + $signed({trim_avg[W], trim_avg});
  assign trim_rate = (trim_sum < RATE_ONE_S) ? W'(1) :
                     (trim_sum > RATE_MAX_S) ? {W{1'b1}} : trim_sum[W-1:0];

  always_ff @(posedge clk_i) begin
    if (!sync_rst_n_i) trim_cnt_q <= '0;
    else               trim_cnt_q <= trim_cnt_d;
  end
`endif

  always_comb begin
    state_d       = state_q;
    rate_d        = rate_q;
    rate_valid_d  = rate_valid_q;
    amount_d      = amount_q;
    lock_cnt_d    = lock_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    dir_d         = dir_q;
    dir_seen_d    = dir_seen_q;
    locked_d      = locked_q;
    hist_d        = hist_q;
    drift_pulse_d = 1'b0;
    lost_d        = 1'b0;
`ifdef LOCKIN_TRACKER_RATE_TRIM_EN
    trim_cnt_d    = trim_cnt_q;
`endif
    if (clk_en_i) begin
      if (clear_state_i || !lockin_en_i) begin
        state_d      = lockin_en_i ? ACQUIRE : IDLE;
        rate_d       = '0;
        rate_valid_d = 1'b0;
        amount_d     = '0;
        lock_cnt_d   = '0;
        miss_cnt_d   = '0;
        dir_d        = 1'b0;
        dir_seen_d   = 1'b0;
        locked_d     = 1'b0;
        hist_d       = '0;
`ifdef LOCKIN_TRACKER_RATE_TRIM_EN
        trim_cnt_d   = '0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            state_d = ACQUIRE;
            hist_d  = '0;
          end
          ACQUIRE: if (event_i) begin
            rate_d       = rate_accumulator_i;
            rate_valid_d = 1'b1;
            state_d      = TRACK;
          end
          TRACK: if (event_i) begin
            if (half_hit) begin
              rate_d     = rate_accumulator_i;
              lock_cnt_d = '0;
            end else if (in_window) begin
              lock_cnt_d    = lock_inc;
              hist_d        = hist_push;
              amount_d      = drift_amt;
              drift_pulse_d = 1'b1;
              if (is_late || is_early) begin
                dir_d      = is_late;
                dir_seen_d = 1'b1;
              end
              if (lock_inc >= required_lockin_i) begin
                state_d    = LOCKED;
                locked_d   = 1'b1;
                miss_cnt_d = '0;
`ifdef LOCKIN_TRACKER_RATE_TRIM_EN
                trim_cnt_d = '0;
`endif
              end
            end else begin
              lock_cnt_d = '0;
            end
          end
          LOCKED: if (event_i) begin
            if (in_window) begin
              miss_cnt_d    = '0;
              hist_d        = hist_push;
              amount_d      = drift_amt;
              drift_pulse_d = 1'b1;
              if (is_late || is_early) begin
                dir_d      = is_late;
                dir_seen_d = 1'b1;
              end
`ifdef LOCKIN_TRACKER_RATE_TRIM_EN
              trim_cnt_d = trim_inc;
              if (trim_inc >= TRIM_FULL && trim_avg != '0) begin
                rate_d     = trim_rate;
                hist_d     = '0;
                trim_cnt_d = '0;
              end
`endif
            end else if (miss_inc >= miss_limit) begin
              state_d    = TRACK;
              locked_d   = 1'b0;
              lost_d     = 1'b1;
              lock_cnt_d = '0;
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_inc;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!sync_rst_n_i) begin
      state_q       <= IDLE;
      rate_q        <= '0;
      rate_valid_q  <= 1'b0;
      amount_q      <= '0;
      lock_cnt_q    <= '0;
      miss_cnt_q    <= '0;
      dir_q         <= 1'b0;
      dir_seen_q    <= 1'b0;
      locked_q      <= 1'b0;
      hist_q        <= '0;
      drift_pulse_q <= 1'b0;
      lost_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rate_q        <= rate_d;
      rate_valid_q  <= rate_valid_d;
      amount_q      <= amount_d;
      lock_cnt_q    <= lock_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      dir_q         <= dir_d;
      dir_seen_q    <= dir_seen_d;
      locked_q      <= locked_d;
      hist_q        <= hist_d;
      drift_pulse_q <= drift_pulse_d;
      lost_q        <= lost_d;
    end
  end

  assign active_rate_o       = rate_q;
  assign active_rate_valid_o = rate_valid_q;
  assign drift_valid_o       = drift_pulse_q;
  assign drift_direction_o   = dir_q;
  assign drift_amount_o      = amount_q;
  assign avg_drift_o         = hist_avg(hist_q);
  assign locked_in_o         = locked_q;
  assign lock_lost_o         = lost_q;
  assign state_o             = state_q;
endmodule

// File: tb/tb_lockin_tracker.sv
// tb/tb_lockin_tracker.sv - vector table, corner sequences and randomized model check for lockin_tracker
module tb_lockin_tracker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ce, en, clr, ev, full;
  logic [15:0] samp, win;
  logic [7:0]  req, lim;
  logic [15:0] rate_o, amt_o;
  logic [16:0] avg_o;
  logic        valid_o, dv_o, dir_o, locked_o, lost_o;
  logic [1:0]  st_o;

  lockin_tracker dut (
    .clk_i(clk), .sync_rst_n_i(rst_n), .clk_en_i(ce), .lockin_en_i(en),
    .clear_state_i(clr), .event_i(ev), .rate_accumulator_i(samp),
    .drift_window_i(win), .full_drift_direction_en_i(full),
    .required_lockin_i(req), .unlock_miss_limit_i(lim),
    .active_rate_o(rate_o), .active_rate_valid_o(valid_o), .drift_valid_o(dv_o),
    .drift_direction_o(dir_o), .drift_amount_o(amt_o), .avg_drift_o(avg_o),
    .locked_in_o(locked_o), .lock_lost_o(lost_o), .state_o(st_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input int st, input int rate, input int valid, input int locked,
                                       input int dv, input int dir, input int lost, input int amt,
                                       input int avg);
    return {8'b0, 2'(st), 16'(rate), 1'(valid), 1'(locked), 1'(dv), 1'(dir), 1'(lost), 16'(amt), 17'(avg)};
  endfunction

  function automatic logic [63:0] act_pack();
    return {8'b0, st_o, rate_o, valid_o, locked_o, dv_o, dir_o, lost_o, amt_o, avg_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst_n, en, clr, ev, full;
    logic [15:0] s;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic e, input logic c, input logic v, input logic f,
                              input int s, input int st, input int rate, input int valid, input int locked,
                              input int dv, input int dir, input int lost, input int amt, input int avg);
    vec_t x;
    x.rst_n = r; x.en = e; x.clr = c; x.ev = v; x.full = f; x.s = 16'(s);
    x.exp = pack(st, rate, valid, locked, dv, dir, lost, amt, avg);
    return x;
  endfunction

  // Reference model: integer arithmetic over the classification rules, history kept as a queue.
  int m_st, m_rate, m_valid, m_lock, m_miss, m_dir, m_seen, m_amt, m_locked, m_dv, m_lost;
  int m_hist[$];

  task automatic model_clear();
    m_rate = 0; m_valid = 0; m_lock = 0; m_miss = 0; m_dir = 0; m_seen = 0;
    m_amt = 0; m_locked = 0; m_hist.delete();
  endtask

  task automatic model_record(input int d);
    m_amt = (d < 0) ? -d : d;
    if (d > 0) begin m_dir = 1; m_seen = 1; end
    else if (d < 0) begin m_dir = 0; m_seen = 1; end
    m_dv = 1;
    m_hist.push_front(d);
    if (m_hist.size() > 4) void'(m_hist.pop_back());
  endtask

  function automatic int model_avg();
    int sum = 0;
    foreach (m_hist[i]) sum += m_hist[i];
    return sum >>> 2;
  endfunction

  task automatic model_step();
    int s, w, d, half, lim_eff;
    bit hh, inw, late_ok, early_ok;
    if (!rst_n) begin
      model_clear(); m_st = 0; m_dv = 0; m_lost = 0;
      return;
    end
    m_dv = 0; m_lost = 0;
    if (!ce) return;
    if (clr || !en) begin
      model_clear(); m_st = en ? 1 : 0;
      return;
    end
    s = int'(samp); w = int'(win); d = s - m_rate; half = m_rate / 2;
    hh = (s - half <= w) && (half - s <= w);
    late_ok  = full || !m_seen || m_dir == 1;
    early_ok = full || !m_seen || m_dir == 0;
    inw = !hh && (d == 0 || (d > 0 && d <= w && late_ok) || (d < 0 && -d <= w && early_ok));
    lim_eff = (lim == 0) ? 1 : int'(lim);
    case (m_st)
      0: begin m_st = 1; m_hist.delete(); end
      1: if (ev) begin m_rate = s; m_valid = 1; m_st = 2; end
      2: if (ev) begin
        if (hh) begin m_rate = s; m_lock = 0; end
        else if (inw) begin
          m_lock = (m_lock < 255) ? m_lock + 1 : 255;
          model_record(d);
          if (m_lock >= int'(req)) begin m_st = 3; m_locked = 1; m_miss = 0; end
        end else m_lock = 0;
      end
      default: if (ev) begin
        if (inw) begin m_miss = 0; model_record(d); end
        else begin
          m_miss++;
          if (m_miss >= lim_eff) begin m_st = 2; m_locked = 0; m_lost = 1; m_lock = 0; m_miss = 0; end
        end
      end
    endcase
  endtask

  initial begin
    int off, v;
    rst_n = 0; ce = 1; en = 0; clr = 0; ev = 0; full = 0; samp = 0; win = 4; req = 3; lim = 2;

    //         r  e  c  v  f  s     st rate val lk dv dir lost amt avg
    vecs.push_back(mk(0, 1, 0, 1, 0, 100, 0, 0,   0,  0, 0, 0,  0,   0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 100, 0, 0,   0,  0, 0, 0,  0,   0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 100, 0, 0,   0,  0, 0, 0,  0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,   1, 0,   0,  0, 0, 0,  0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 100, 2, 100, 1,  0, 0, 0,  0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,   2, 100, 1,  0, 0, 0,  0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 102, 2, 100, 1,  0, 1, 1,  0,   2, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 101, 2, 100, 1,  0, 1, 1,  0,   1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 103, 3, 100, 1,  1, 1, 1,  0,   3, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,   3, 100, 1,  1, 0, 1,  0,   3, 1));
    vecs.push_back(mk(1, 1, 0, 1, 0, 120, 3, 100, 1,  1, 0, 1,  0,   3, 1));
    vecs.push_back(mk(1, 1, 0, 1, 0, 120, 2, 100, 1,  0, 0, 1,  1,   3, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,   2, 100, 1,  0, 0, 1,  0,   3, 1));
    vecs.push_back(mk(1, 1, 0, 1, 0, 100, 2, 100, 1,  0, 1, 1,  0,   0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 0, 97,  2, 100, 1,  0, 0, 1,  0,   0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 1, 97,  2, 100, 1,  0, 1, 0,  0,   3, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 99,  2, 100, 1,  0, 1, 0,  0,   1, -1));
    vecs.push_back(mk(1, 1, 0, 1, 1, 104, 3, 100, 1,  1, 1, 1,  0,   4, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 100, 1, 0,   0,  0, 0, 0,  0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 100, 2, 100, 1,  0, 0, 0,  0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 51,  2, 51,  1,  0, 0, 0,  0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 52,  2, 51,  1,  0, 1, 1,  0,   1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0,   0,  0, 0, 0,  0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,   1, 0,   0,  0, 0, 0,  0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 60,  2, 60,  1,  0, 0, 0,  0,   0, 0));

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; en = vecs[i].en; clr = vecs[i].clr;
      ev = vecs[i].ev; full = vecs[i].full; samp = vecs[i].s;
      tick();
      chk($sformatf("vec%0d", i), act_pack(), vecs[i].exp);
    end

    // Zero lock requirement and zero miss limit, pulse widths, clock enable hold.
    rst_n = 0; ev = 0; clr = 0; full = 0; tick();
    chk("rst_state", 64'(st_o), 64'd0);
    rst_n = 1; en = 1; req = 0; lim = 0; tick();
    chk("req0_acq", 64'(st_o), 64'd1);
    ev = 1; samp = 200; tick();
    chk("req0_rate", 64'(rate_o), 64'd200);
    samp = 201; tick();
    chk("req0_lock", {62'b0, st_o}, 64'd3);
    chk("req0_locked", 64'(locked_o), 64'd1);
    ev = 0; tick();
    chk("dv_one_clk", 64'(dv_o), 64'd0);
    ev = 1; samp = 100; tick();
    chk("lim0_lost", 64'(lost_o), 64'd1);
    chk("lim0_state", 64'(st_o), 64'd2);
    ev = 0; tick();
    chk("lost_one_clk", 64'(lost_o), 64'd0);
    ce = 0; ev = 1; samp = 300; tick();
    chk("ce_hold_rate", 64'(rate_o), 64'd200);
    en = 0; tick();
    chk("ce_hold_state", 64'(st_o), 64'd2);
    ce = 1; en = 1; ev = 0;

    // Randomized run against the reference model.
    rst_n = 0; tick(); model_step();
    chk("rand_reset", act_pack(), pack(m_st, m_rate, m_valid, m_locked, m_dv, m_dir, m_lost, m_amt, model_avg()));
    rst_n = 1; win = 4; req = 3; lim = 2;
    for (int cyc = 0; cyc < 4000 && bad < 20; cyc++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      ce    = ($urandom_range(0, 7) != 0);
      en    = ($urandom_range(0, 149) != 0);
      clr   = ($urandom_range(0, 149) == 0);
      ev    = $urandom_range(0, 1);
      full  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) win = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) req = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 39) == 0) lim = 8'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin off = int'($urandom_range(0, 12)) - 6; v = m_rate + off; end
        6, 7:             begin off = int'($urandom_range(0, 12)) - 6; v = m_rate / 2 + off; end
        default:          v = int'($urandom_range(20, 400));
      endcase
      if (v < 0) v = 0;
      if (v > 65535) v = 65535;
      samp = 16'(v);
      tick();
      model_step();
      chk($sformatf("rand%0d", cyc), act_pack(),
          pack(m_st, m_rate, m_valid, m_locked, m_dv, m_dir, m_lost, m_amt, model_avg()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lockin_tracker.md
Name: lockin_tracker

Overview:
Parametrised successor of the single-channel lock-in checker. It tracks the bit-period rate from polarity-filtered edge events, classifies each event as half-rate, in-window drift or miss, and owns the active rate register itself. It adds hysteresis: lock after N consecutive in-window events, unlock after M consecutive misses. It also keeps a moving drift average for downstream clock recovery.

Parameters:
RATE_WIDTH, 16, width of rate accumulator, active rate, window and drift values
LOCK_CNT_WIDTH, 8, width of lock, miss and limit counters
DRIFT_AVG_DEPTH, 4, drift history entries; power of 2, at least 2

Ports:
clk_i  in  1  system clock
sync_rst_n_i  in  1  synchronous reset, active-low
clk_en_i  in  1  clock enable; no state advances when low
lockin_en_i  in  1  tracker enable
clear_state_i  in  1  synchronous clear of all tracking state
event_i  in  1  polarity-filtered edge event
rate_accumulator_i  in  RATE_WIDTH  cycles since the previous edge, sampled with event_i
drift_window_i  in  RATE_WIDTH  allowed drift, in either direction
full_drift_direction_en_i  in  1  accept both drift directions
required_lockin_i  in  LOCK_CNT_WIDTH  consecutive hits needed to lock
unlock_miss_limit_i  in  LOCK_CNT_WIDTH  consecutive misses needed to unlock
active_rate_o  out  RATE_WIDTH  current bit-period estimate
active_rate_valid_o  out  1  active rate captured
drift_valid_o  out  1  one-cycle pulse: in-window event classified
drift_direction_o  out  1  1 = pin came late, 0 = pin came early
drift_amount_o  out  RATE_WIDTH  absolute value of (sample minus active rate)
avg_drift_o  out  RATE_WIDTH+1  signed average of the drift history
locked_in_o  out  1  lock status
lock_lost_o  out  1  one-cycle pulse on LOCKED to TRACK
state_o  out  2  0=IDLE, 1=ACQUIRE, 2=TRACK, 3=LOCKED

Behaviour:
- Reset (sync_rst_n_i=0 at a clock edge): all outputs 0, state IDLE, all counters and history cleared. Reset has the highest priority.
- clear_state_i (when clk_en_i=1) has priority over event_i.
  - Clears rate, counters, history and direction.
  - Next state is ACQUIRE if lockin_en_i=1, else IDLE.
- lockin_en_i=0 (when clk_en_i=1): next state IDLE, same clearing as clear_state_i.
- Event handling:
  - An event is processed when event_i, clk_en_i and lockin_en_i are all 1.
  - Registered outputs update one clock after the event.
  - Pulses (drift_valid_o, lock_lost_o) are high for exactly one clock.
- Bounds arithmetic:
  - All bounds are computed in RATE_WIDTH+1 bits.
  - Upper bounds saturate at all-ones; lower bounds floor at 0.
  - half = active_rate >> 1.
- Direction gating:
  - The late side (sample > rate) is allowed if full_drift_direction_en_i=1, or the stored direction is late, or no drift has been recorded yet.
  - The early side follows the same rule.
  - sample == rate is always in-window: amount 0, stored direction unchanged.
- Classification, in priority order:
  - half-hit: half - win <= sample <= half + win.
  - in-window: |sample - rate| <= win on an allowed side.
  - Otherwise: miss.
- IDLE: goes to ACQUIRE on the next enabled clock when lockin_en_i=1.
- ACQUIRE: the first event sets active_rate = sample and valid=1, then goes to TRACK.
- TRACK:
  - half-hit: active_rate = sample, lock count = 0.
  - in-window: lock count +1 (saturating), push drift into history, pulse drift_valid_o. When the new count is >= required_lockin_i, go to LOCKED and set locked_in_o=1.
  - miss: lock count = 0.
  - required_lockin_i=0: lock on the first in-window event.
- LOCKED:
  - in-window: miss count = 0, push drift into history, pulse drift_valid_o.
  - half-hit or miss: miss count +1. When the count reaches unlock_miss_limit_i (a limit of 0 is treated as 1), go to TRACK with locked_in_o=0, pulse lock_lost_o, clear lock and miss counts.
  - active_rate is not replaced while LOCKED.
- Drift history:
  - Shift register of signed values; +amount for late, -amount for early.
  - avg_drift_o = arithmetic right shift of the sum by log2(DEPTH); the sum is held in RATE_WIDTH+1+log2(DEPTH) bits.
  - Empty entries read as 0.
  - Cleared on reset, clear, disable and ACQUIRE entry.

Optional Feature:
Macro LOCKIN_TRACKER_RATE_TRIM_EN.
- Defined: in LOCKED, after DRIFT_AVG_DEPTH in-window events since the last trim, if avg_drift is nonzero:
  - active_rate = active_rate + avg_drift, saturated to the range 1 .. all-ones;
  - history is cleared;
  - applied in the same cycle as the last pushed event.
- Undefined: active_rate stays constant in LOCKED; the history is only reported.

Test Plan:
All scenarios use RATE_WIDTH=16, DEPTH=4, win=4, req=3, miss limit=2, clk_en_i=1.
1. Reset: hold rst_n=0 for 3 clocks while toggling event_i -> all outputs 0, state_o=0.
2. Acquire/lock: enable, events at 100, then 102, 101, 103 -> active_rate_o=100 and state TRACK after the first event. The following three events give drift_valid pulses with late direction, amounts 2, 1, 3. locked_in_o=1 one clock after 103. avg_drift_o=1 (sum 6 >>> 2).
3. Half-rate: TRACK, rate 100, event 51 -> active_rate_o=51, lock count 0, no drift pulse.
4. Gating: after late drift, event 97 with full_dir=0 -> miss, count reset. Same with full_dir=1 -> in-window, early direction, amount 3.
5. Unlock: LOCKED, events 120, 120 -> lock_lost_o pulses one clock after the second event, state_o=2, locked_in_o=0. A third event at 100 gives count 1.
6. Clear mid-lock: LOCKED, assert clear_state_i together with event_i -> clear wins. state_o=1, active_rate_valid_o=0, avg_drift_o=0.
